// File: rtl/addsub_div_sequencer.sv
// ============================================================================
//  Module      : addsub_div_sequencer
//  Description : Multi-cycle unsigned restoring divider. Owns no arithmetic:
//                each RUN cycle it presents a trial subtraction to the shared
//                32-bit add/sub unit and consumes the combinational result.
//                Returns quotient, remainder and a divide-by-zero flag with a
//                one-cycle done pulse.
//  Options     : DIVSEQ_ABORT_EN - adds an 'abort' input that cancels an
//                in-flight division without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_div_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef DIVSEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [31:0]      as_a,
   output logic [31:0]      as_b,
   output logic             as_sub,
   input  logic [31:0]      as_f
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] quo_q;
   // The partial remainder is always below the divisor, so WIDTH bits hold it;
   // the extra trial bit is rebuilt each cycle from the shifted-in dividend bit.
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   // Only the low result bits and the sign bit of the shared unit are consumed.
   logic unused_as_f;
   assign unused_as_f = &{1'b0, as_f};

   // Trial subtraction request and restore/commit decision for one iteration.
   always_comb begin
      trial_d = {rem_q, quo_q[WIDTH-1]};
      as_a    = 32'd0;
      as_b    = 32'd0;
      as_sub  = 1'b0;
      if (state_q == S_RUN) begin
         as_a   = 32'(trial_d);
         as_b   = 32'(div_q);
         as_sub = 1'b1;
      end
      if (!as_f[31]) begin
         rem_d = as_f[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = trial_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM plus iteration datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         quo_q       <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     // No iterations: report saturated quotient immediately.
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     dbz_q       <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     quo_q   <= dividend;
                     rem_q   <= '0;
                     div_q   <= divisor;
                     cnt_q   <= CW'(WIDTH);
                     dbz_q   <= 1'b0;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
`ifdef DIVSEQ_ABORT_EN
               if (abort) begin
                  state_q <= S_IDLE;
               end else
`endif
               begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     quotient_q  <= quo_d;
                     remainder_q <= rem_d;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_div_sequencer.sv
// ============================================================================
//  Module      : tb_addsub_div_sequencer
//  Description : Directed self-checking bench for addsub_div_sequencer with a
//                behavioural model of the shared add/sub unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_div_sequencer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
`ifdef DIVSEQ_ABORT_EN
   logic          abort = 1'b0;
`endif
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;
   logic [31:0]   as_a;
   logic [31:0]   as_b;
   logic          as_sub;
   logic [31:0]   as_f;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Shared add/sub unit model
   assign as_f = as_sub ? (as_a - as_b) : (as_a + as_b);

   addsub_div_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
`ifdef DIVSEQ_ABORT_EN
      .abort       (abort),
`endif
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .as_a        (as_a),
      .as_b        (as_b),
      .as_sub      (as_sub),
      .as_f        (as_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge; returns just after the accepting edge.
   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   // Count edges until done is seen and how many sampled cycles had as_sub=1.
   task automatic wait_done(output int n, output int subs);
      n    = 0;
      subs = 0;
      while (!done && n < 100) begin
         if (as_sub) subs++;
         step();
         n++;
      end
   endtask

   int n, subs;

   initial begin
      // Reset state
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quo", 32'(quotient), 32'd0);
      chk("rst_rem", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      chk("rst_as_a", as_a, 32'd0);
      chk("rst_as_sub", 32'(as_sub), 32'd0);
      rst = 1'b0;
      step();

      // 100 / 7
      do_start(16'd100, 16'd7);
      chk("a_busy", 32'(busy), 32'd1);
      wait_done(n, subs);
      chk("a_latency", 32'(n), 32'd16);
      chk("a_sub_cycles", 32'(subs), 32'd16);
      chk("a_quo", 32'(quotient), 32'd14);
      chk("a_rem", 32'(remainder), 32'd2);
      chk("a_dbz", 32'(div_by_zero), 32'd0);
      step();
      chk("a_done_pulse", 32'(done), 32'd0);
      chk("a_idle_busy", 32'(busy), 32'd0);
      chk("a_idle_as_b", as_b, 32'd0);

      // 0xFFFF / 1
      do_start(16'hFFFF, 16'h0001);
      wait_done(n, subs);
      chk("b_quo", 32'(quotient), 32'h0000FFFF);
      chk("b_rem", 32'(remainder), 32'd0);
      step();

      // 3 / 10, previous result held while running
      do_start(16'd3, 16'd10);
      step(); step(); step();
      chk("c_held_quo", 32'(quotient), 32'h0000FFFF);
      chk("c_held_rem", 32'(remainder), 32'd0);
      wait_done(n, subs);
      chk("c_latency", 32'(n), 32'd13);
      chk("c_quo", 32'(quotient), 32'd0);
      chk("c_rem", 32'(remainder), 32'd3);
      step();

      // 5 / 0
      do_start(16'd5, 16'd0);
      wait_done(n, subs);
      chk("d_latency", 32'(n), 32'd0);
      chk("d_sub_cycles", 32'(subs), 32'd0);
      chk("d_as_sub", 32'(as_sub), 32'd0);
      chk("d_quo", 32'(quotient), 32'h0000FFFF);
      chk("d_rem", 32'(remainder), 32'd5);
      chk("d_dbz", 32'(div_by_zero), 32'd1);
      step();
      chk("d_done_pulse", 32'(done), 32'd0);

      // 1000 / 33 with ignored starts during RUN and DONE
      do_start(16'd1000, 16'd33);
      step(); step(); step();
      do_start(16'd9, 16'd3);
      wait_done(n, subs);
      chk("e_latency", 32'(n), 32'd12);
      chk("e_quo", 32'(quotient), 32'd30);
      chk("e_rem", 32'(remainder), 32'd10);
      chk("e_dbz", 32'(div_by_zero), 32'd0);
      do_start(16'd9, 16'd3);
      chk("e_start_in_done_busy", 32'(busy), 32'd0);
      chk("e_start_in_done_done", 32'(done), 32'd0);
      step();
      chk("e_no_second_done", 32'(done), 32'd0);
      chk("e_quo_kept", 32'(quotient), 32'd30);

      // Asynchronous reset mid-RUN
      do_start(16'd50000, 16'd123);
      repeat (7) step();
      #2 rst = 1'b1;
      #1;
      chk("f_rst_busy", 32'(busy), 32'd0);
      chk("f_rst_done", 32'(done), 32'd0);
      chk("f_rst_quo", 32'(quotient), 32'd0);
      chk("f_rst_rem", 32'(remainder), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("f_no_done", 32'(done), 32'd0);
      do_start(16'd50000, 16'd123);
      wait_done(n, subs);
      chk("f_latency", 32'(n), 32'd16);
      chk("f_quo", 32'(quotient), 32'd406);
      chk("f_rem", 32'(remainder), 32'd62);
      step();

`ifdef DIVSEQ_ABORT_EN
      // Abort mid-RUN retains previous results
      do_start(16'd100, 16'd7);
      wait_done(n, subs);
      chk("g_quo", 32'(quotient), 32'd14);
      step();
      do_start(16'd200, 16'd9);
      repeat (4) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("g_abort_busy", 32'(busy), 32'd0);
      chk("g_abort_done", 32'(done), 32'd0);
      chk("g_abort_quo", 32'(quotient), 32'd14);
      chk("g_abort_rem", 32'(remainder), 32'd2);
      repeat (15) step();
      chk("g_abort_no_done", 32'(done), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/addsub_div_sequencer.md
Name: addsub_div_sequencer

Overview:
Multi-cycle unsigned restoring divider. It owns no arithmetic of its own: it drives the team's shared 32-bit add/sub unit and reads back its result, one iteration per clock. It sits beside the add/sub unit in the ALU and is started by the decode/control logic for DIV/MOD operations. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand width in bits; legal range 2..31 (WIDTH+1 must fit in the 32-bit datapath so F[31] is a valid sign bit).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when results are valid
quotient  output  WIDTH  registered quotient; held until next accepted start
remainder  output  WIDTH  registered remainder; held until next accepted start
div_by_zero  output  1  registered; set when divisor was 0; held like quotient
as_a  output  32  add/sub operand A (zero-extended trial remainder)
as_b  output  32  add/sub operand B (zero-extended divisor)
as_sub  output  1  add/sub select: 1 = subtract
as_f  input  32  add/sub result F, combinational from as_a/as_b/as_sub

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0: latch quo_r=dividend, rem_r=0 (WIDTH+1 bits), div_r=divisor, cnt=WIDTH. Clear div_by_zero. Go to RUN.
- IDLE, start=1, divisor==0: no iterations. quotient=all ones, remainder=dividend, div_by_zero=1. Go to DONE.
- RUN, each cycle:
  - trial={rem_r[WIDTH-1:0], quo_r[WIDTH-1]}; as_a=zero-ext(trial), as_b=zero-ext(div_r), as_sub=1.
  - If as_f[31]==0: rem_r<=as_f[WIDTH:0], quo_r<={quo_r[WIDTH-2:0],1'b1}.
  - Else: rem_r<=trial, quo_r<={quo_r[WIDTH-2:0],1'b0}.
  - cnt decrements. On the cycle cnt==1, update quotient<=new quo_r and remainder<=new rem_r[WIDTH-1:0], then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Outside RUN: as_a=0, as_b=0, as_sub=0.
- Latency: start accepted at edge k gives done high during cycle k+WIDTH+1. Divide-by-zero gives done during cycle k+1.
- start while busy=1: ignored; in-flight operation unaffected.
- rst mid-operation: immediate return to IDLE with reset values. No done pulse.
- Outputs quotient/remainder/div_by_zero change only at the completion edge or on rst.

Optional Feature:
DIVSEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN: next state IDLE, busy drops, no done pulse, quotient/remainder/div_by_zero keep their previous values.
  - abort in IDLE/DONE: no effect.
  - abort and rst together: rst wins.
- Undefined: no abort port; RUN always completes WIDTH iterations.

Test Plan:
- WIDTH=16, start with 100/7 -> done at cycle 17 after start; quotient=14, remainder=2, div_by_zero=0; as_sub=1 for exactly 16 cycles.
- 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0. Then 3/10 -> quotient=0, remainder=3; previous results held until second completion.
- 5/0 -> done one cycle after start; quotient=0xFFFF, remainder=5, div_by_zero=1, no RUN cycles (as_sub stays 0).
- 1000/33 started, start pulsed again with 9/3 at cycles 4 and 17 (DONE) -> both ignored; result quotient=30, remainder=10, single done pulse.
- rst asserted asynchronously mid-RUN (cycle 8 of 50000/123) -> busy=0 and outputs 0 immediately, no done. New 50000/123 after release -> quotient=406, remainder=62.
- DIVSEQ_ABORT_EN defined: after 100/7 completes, start 200/9 and abort at RUN cycle 5 -> IDLE next cycle, no done, quotient=14, remainder=2 retained.
